// File: rtl/lap_recorder_if.sv
// Interface bundling the timer stream, lap/clear controls and the FIFO read port of lap_recorder.
interface lap_recorder_if #(
  parameter int W     = 16,
  parameter int DEPTH = 8
);
  logic                     t_valid;
  logic [W-1:0]             t_out;
  logic                     lap;
  logic                     clear;
  logic                     rd_ready;
  logic                     rd_valid;
  logic [W-1:0]             rd_stamp;
  logic [W-1:0]             rd_delta;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     empty;
  logic                     overflow;

  modport master (
    output t_valid, t_out, lap, clear, rd_ready,
    input  rd_valid, rd_stamp, rd_delta, count, full, empty, overflow
  );

  modport slave (
    input  t_valid, t_out, lap, clear, rd_ready,
    output rd_valid, rd_stamp, rd_delta, count, full, empty, overflow
  );
endinterface

// File: rtl/lap_recorder.sv
// Lap recorder: captures timer stamps (and, with LAP_RECORDER_DELTA_EN, lap deltas) into a FWFT FIFO.
// Macro LAP_RECORDER_DELTA_EN enables the prev/v_d tracking, subtractor and 2W-bit entries.
module lap_recorder #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input logic           clk,
  input logic           rst,
  lap_recorder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef LAP_RECORDER_DELTA_EN
  localparam int EW = 2 * W;
`else
  localparam int EW = W;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          is_full, is_empty;
  logic          push, pop, accept, drop;
  logic [EW-1:0] wr_entry;

  assign is_full  = (cnt == CW'(DEPTH));
  assign is_empty = (cnt == '0);
  assign push     = bus.lap & bus.t_valid;
  assign pop      = !is_empty & bus.rd_ready;
  // A pop in the same cycle frees the slot the push needs when full.
  assign accept   = push & (!is_full | pop);
  assign drop     = push & is_full & !pop;

`ifdef LAP_RECORDER_DELTA_EN
  logic         v_d;
  logic         run_start;
  logic [W-1:0] prev, base, delta;

  assign run_start = bus.t_valid & !v_d;
  assign base      = run_start ? bus.t_out : prev;
  assign delta     = bus.t_out - base;
  assign wr_entry  = {delta, bus.t_out};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_d  <= 1'b0;
      prev <= '0;
    end else if (bus.clear) begin
      v_d  <= 1'b0;
      prev <= '0;
    end else begin
      v_d <= bus.t_valid;
      if (push || run_start) prev <= bus.t_out;
    end
  end

  assign bus.rd_delta = is_empty ? '0 : mem[rd_ptr][2*W-1:W];
`else
  assign wr_entry     = bus.t_out;
  assign bus.rd_delta = '0;
`endif

  // Storage has no reset; outputs are masked to 0 while empty.
  always_ff @(posedge clk) begin
    if (accept && !bus.clear) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

  assign bus.rd_stamp = is_empty ? '0 : mem[rd_ptr][W-1:0];
  assign bus.rd_valid = !is_empty;
  assign bus.count    = cnt;
  assign bus.full     = is_full;
  assign bus.empty    = is_empty;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_lap_recorder.sv
// Self-checking bench for lap_recorder: vector table, corner sequences and randomized traffic vs a queue model.
module tb_lap_recorder;
  localparam int W     = 16;
  localparam int DEPTH = 8;
`ifdef LAP_RECORDER_DELTA_EN
  localparam bit DELTA_EN = 1'b1;
`else
  localparam bit DELTA_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  lap_recorder_if #(.W(W), .DEPTH(DEPTH)) bus ();
  lap_recorder #(.DEPTH(DEPTH), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] stamp;
    logic [W-1:0] delta;
  } ent_t;

  typedef struct {
    logic         tv;
    logic [W-1:0] to;
    logic         lap;
    logic         rr;
    int           cnt;
    logic [W-1:0] stamp;
    logic [W-1:0] delta;
  } vec_t;

  // Reference model: queue of records plus run/lap bookkeeping.
  ent_t         q[$];
  logic [W-1:0] m_prev;
  bit           m_vd;
  bit           m_ovf;

  function automatic void modelReset();
    q.delete();
    m_prev = '0;
    m_vd   = 1'b0;
    m_ovf  = 1'b0;
  endfunction

  function automatic void modelStep(input logic tv, input logic [W-1:0] to,
                                    input logic lp, input logic clr, input logic rr);
    bit           do_pop;
    bit           starting;
    ent_t         e;
    if (clr) begin
      modelReset();
      return;
    end
    do_pop   = rr && (q.size() > 0);
    starting = tv && !m_vd;
    if (do_pop) void'(q.pop_front());
    if (lp && tv) begin
      e.stamp = to;
      e.delta = to - (starting ? to : m_prev);
      if (q.size() < DEPTH) q.push_back(e);
      else m_ovf = 1'b1;
      m_prev = to;
    end else if (starting) begin
      m_prev = to;
    end
    m_vd = tv;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [W-1:0] es, ed;
    es = '0;
    ed = '0;
    if (q.size() > 0) begin
      es = q[0].stamp;
      ed = DELTA_EN ? q[0].delta : '0;
    end
    checkVal({tag, " rd_valid"}, 32'(bus.rd_valid), 32'(q.size() > 0));
    checkVal({tag, " rd_stamp"}, 32'(bus.rd_stamp), 32'(es));
    checkVal({tag, " rd_delta"}, 32'(bus.rd_delta), 32'(ed));
    checkVal({tag, " count"},    32'(bus.count),    32'(q.size()));
    checkVal({tag, " full"},     32'(bus.full),     32'(q.size() == DEPTH));
    checkVal({tag, " empty"},    32'(bus.empty),    32'(q.size() == 0));
    checkVal({tag, " overflow"}, 32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic applyStimulus(input logic tv, input logic [W-1:0] to, input logic lp,
                               input logic clr, input logic rr);
    @(negedge clk);
    bus.t_valid  = tv;
    bus.t_out    = to;
    bus.lap      = lp;
    bus.clear    = clr;
    bus.rd_ready = rr;
    if (!rst) modelStep(tv, to, lp, clr, rr);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[11];

  initial begin
    logic [W-1:0] tcnt;
    bit           tv_r;

    vecs[0]  = '{1'b0, 16'd0,      1'b0, 1'b0, 0, 16'd0,      16'd0};
    vecs[1]  = '{1'b1, 16'd100,    1'b0, 1'b0, 0, 16'd0,      16'd0};
    vecs[2]  = '{1'b1, 16'd150,    1'b1, 1'b0, 1, 16'd150,    16'd50};
    vecs[3]  = '{1'b1, 16'd400,    1'b1, 1'b0, 2, 16'd150,    16'd50};
    vecs[4]  = '{1'b1, 16'd410,    1'b0, 1'b1, 1, 16'd400,    16'd250};
    vecs[5]  = '{1'b1, 16'd420,    1'b0, 1'b1, 0, 16'd0,      16'd0};
    vecs[6]  = '{1'b0, 16'd0,      1'b1, 1'b0, 0, 16'd0,      16'd0};
    vecs[7]  = '{1'b1, 16'd7,      1'b1, 1'b0, 1, 16'd7,      16'd0};
    vecs[8]  = '{1'b1, 16'hFFF0,   1'b1, 1'b1, 1, 16'hFFF0,   16'hFFE9};
    vecs[9]  = '{1'b1, 16'h0010,   1'b1, 1'b1, 1, 16'h0010,   16'h0020};
    vecs[10] = '{1'b1, 16'h0020,   1'b0, 1'b1, 0, 16'd0,      16'd0};

    bus.t_valid  = 1'b0;
    bus.t_out    = '0;
    bus.lap      = 1'b0;
    bus.clear    = 1'b0;
    bus.rd_ready = 1'b0;
    modelReset();
    #12;
    checkOutput("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic laps, run-start lap, ignored lap and timer wrap
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].tv, vecs[i].to, vecs[i].lap, 1'b0, vecs[i].rr);
      checkVal($sformatf("vec%0d count", i), 32'(bus.count), 32'(vecs[i].cnt));
      checkVal($sformatf("vec%0d stamp", i), 32'(bus.rd_stamp), 32'(vecs[i].stamp));
      checkVal($sformatf("vec%0d delta", i), 32'(bus.rd_delta),
               32'(DELTA_EN ? vecs[i].delta : 16'd0));
      checkVal($sformatf("vec%0d overflow", i), 32'(bus.overflow), 32'd0);
      checkOutput($sformatf("vec%0d", i));
    end

    // Full and overflow, then drain in order
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i <= DEPTH; i++) applyStimulus(1'b1, 16'(1000 + i * 10), 1'b1, 1'b0, 1'b0);
    checkVal("ovf full", 32'(bus.full), 32'd1);
    checkVal("ovf overflow", 32'(bus.overflow), 32'd1);
    checkVal("ovf count", 32'(bus.count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      checkVal($sformatf("ovf drain%0d stamp", i), 32'(bus.rd_stamp), 32'(1000 + i * 10));
      applyStimulus(1'b1, 16'(2000 + i), 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("ovf drain%0d", i));
    end

    // Full with simultaneous push and pop
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 16'(500 + i), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd3000, 1'b1, 1'b0, 1'b1);
    checkVal("fullpop count", 32'(bus.count), 32'(DEPTH));
    checkVal("fullpop overflow", 32'(bus.overflow), 32'd0);
    checkVal("fullpop head", 32'(bus.rd_stamp), 32'd501);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) checkVal("fullpop last", 32'(bus.rd_stamp), 32'd3000);
      applyStimulus(1'b1, 16'(3001 + i), 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("fullpop drain%0d", i));
    end

    // Clear together with a lap, then the next cycle acts as a run start
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'(4000 + i * 5), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd4100, 1'b1, 1'b1, 1'b0);
    checkVal("clear count", 32'(bus.count), 32'd0);
    checkVal("clear empty", 32'(bus.empty), 32'd1);
    checkVal("clear overflow", 32'(bus.overflow), 32'd0);
    applyStimulus(1'b1, 16'd5000, 1'b1, 1'b0, 1'b0);
    checkVal("postclear stamp", 32'(bus.rd_stamp), 32'd5000);
    checkVal("postclear delta", 32'(bus.rd_delta), 32'd0);
    checkOutput("postclear");

    // Asynchronous reset in the middle of a pop cycle
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 16'(5100 + i), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus.lap      = 1'b0;
    bus.rd_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rst midpop");
    checkVal("rst stamp", 32'(bus.rd_stamp), 32'd0);
    @(negedge clk);
    bus.t_valid  = 1'b0;
    bus.rd_ready = 1'b0;
    rst = 1'b0;

    // Randomized traffic against the model
    tcnt = 16'(($urandom() & 32'hFFFF));
    tv_r = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) tv_r = !tv_r;
      tcnt = tcnt + 16'($urandom_range(1, 40));
      applyStimulus(tv_r, tcnt, ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0),
                    ($urandom_range(0, 2) == 0));
      checkOutput($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
